// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: registered ALU issue stage with a 2-entry skid buffer.
// The output register feeds the ALU directly; the skid register absorbs one op so in_ready can be a flop.
module alu_issue_buffer #(
   parameter int WORD_SIZE = 32,
   parameter int CTRL_W    = 4,
   parameter int TAG_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CTRL_W-1:0]    in_alu_control,
   input  logic [WORD_SIZE-1:0] in_a,
   input  logic [WORD_SIZE-1:0] in_b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CTRL_W-1:0]    out_alu_control,
   output logic [WORD_SIZE-1:0] out_a,
   output logic [WORD_SIZE-1:0] out_b,
   output logic [TAG_W-1:0]     out_tag,
   output logic [1:0]           occupancy_out
);
   localparam int PW = CTRL_W + 2 * WORD_SIZE + TAG_W;
   typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
   state_t state;
   logic [PW-1:0] out_q, skid_q, in_p;
   logic accept, fire;
   assign in_p = {in_alu_control, in_a, in_b, in_tag};
   assign {out_alu_control, out_a, out_b, out_tag} = out_q;
   assign occupancy_out = state;
   assign accept = in_valid & in_ready;
   assign fire = out_valid & out_ready;
   // in_ready and out_valid are flops that track the next state, keeping the ready path registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_q     <= '0;
         skid_q    <= '0;
      end else if (flush_in) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            EMPTY: if (accept) begin
               state     <= BUSY;
               out_valid <= 1'b1;
               out_q     <= in_p;
            end
            BUSY: if (accept && !fire) begin
               state    <= FULL;
               in_ready <= 1'b0;
               skid_q   <= in_p;
            end else if (accept) begin
               out_q <= in_p;
            end else if (fire) begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
            FULL: if (fire) begin
               state    <= BUSY;
               in_ready <= 1'b1;
               out_q    <= skid_q;
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end
endmodule
